// File: rtl/matrix_code_row_pipe.sv
// Two-stage matrix-code row checker/corrector with valid/ready flow control
// and saturating corrected/uncorrectable event counters.
module matrix_code_row_pipe #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     p1,
  input  logic [W-1:0]     p2,
  input  logic [W-1:0]     p3,
  input  logic [W-1:0]     p4,
  input  logic [W-1:0]     z1,
  input  logic [W-1:0]     z2,
  input  logic [W-1:0]     z3,
  input  logic             correct_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     q1,
  output logic [W-1:0]     q2,
  output logic [W-1:0]     q3,
  output logic [W-1:0]     q4,
  output logic [2:0]       err_pos,
  output logic             out_unc,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_unc
);

  logic             v1, v2, adv1, adv2;
  logic [W-1:0]     r1, r2, r3, r4;
  logic [W-1:0]     s1, s2, s3;
  logic             ce_r;
  logic             n1, n2, n3;
  logic [2:0]       pos_c;
  logic             unc_c;
  logic [W-1:0]     qc1, qc2, qc3, qc4;
  logic [CNT_W-1:0] cnt_one;

  assign adv2      = !v2 || out_ready;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;
  assign cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};

  // Check words are folded into the syndromes here, so only s* travel on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      r1   <= '0;
      r2   <= '0;
      r3   <= '0;
      r4   <= '0;
      s1   <= '0;
      s2   <= '0;
      s3   <= '0;
      ce_r <= 1'b0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        r1   <= p1;
        r2   <= p2;
        r3   <= p3;
        r4   <= p4;
        s1   <= p1 ^ p2 ^ p3 ^ z1;
        s2   <= p1 ^ p2 ^ p4 ^ z2;
        s3   <= p1 ^ p3 ^ p4 ^ z3;
        ce_r <= correct_en;
      end
    end
  end

  assign n1 = |s1;
  assign n2 = |s2;
  assign n3 = |s3;

  always_comb begin
    pos_c = 3'd0;
    unc_c = 1'b0;
    case ({n3, n2, n1})
      3'b000: pos_c = 3'd0;
      3'b001: pos_c = 3'd5;
      3'b010: pos_c = 3'd6;
      3'b100: pos_c = 3'd7;
      3'b111: if (s1 == s2 && s2 == s3) pos_c = 3'd1; else unc_c = 1'b1;
      3'b011: if (s1 == s2) pos_c = 3'd2; else unc_c = 1'b1;
      3'b101: if (s1 == s3) pos_c = 3'd3; else unc_c = 1'b1;
      3'b110: if (s2 == s3) pos_c = 3'd4; else unc_c = 1'b1;
      default: unc_c = 1'b1;
    endcase
  end

  always_comb begin
    qc1 = r1;
    qc2 = r2;
    qc3 = r3;
    qc4 = r4;
    if (ce_r) begin
      case (pos_c)
        3'd1:    qc1 = r1 ^ s1;
        3'd2:    qc2 = r2 ^ s1;
        3'd3:    qc3 = r3 ^ s1;
        3'd4:    qc4 = r4 ^ s2;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2      <= 1'b0;
      q1      <= '0;
      q2      <= '0;
      q3      <= '0;
      q4      <= '0;
      err_pos <= 3'd0;
      out_unc <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        q1      <= qc1;
        q2      <= qc2;
        q3      <= qc3;
        q4      <= qc4;
        err_pos <= pos_c;
        out_unc <= unc_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_corr <= '0;
      cnt_unc  <= '0;
    end else if (cnt_clr) begin
      cnt_corr <= '0;
      cnt_unc  <= '0;
    end else if (v2 && out_ready) begin
      if (out_unc) begin
        if (!(&cnt_unc)) cnt_unc <= cnt_unc + cnt_one;
      end else if (err_pos != 3'd0) begin
        if (!(&cnt_corr)) cnt_corr <= cnt_corr + cnt_one;
      end
    end
  end

endmodule

// File: tb/tb_matrix_code_row_pipe.sv
// Randomised and directed bench for matrix_code_row_pipe; a wide-counter and a
// 2-bit-counter instance share all inputs and are checked against one model.
module tb_matrix_code_row_pipe;
  localparam int W = 8;

  typedef struct packed {
    logic [3:0][W-1:0] p;
    logic [2:0][W-1:0] z;
    logic              ce;
  } row_t;

  typedef struct packed {
    logic [3:0][W-1:0] q;
    logic [2:0]        pos;
    logic              unc;
    int                cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst, in_valid, correct_en, out_ready, cnt_clr;
  logic [W-1:0] p1, p2, p3, p4, z1, z2, z3;
  logic in_ready, out_valid, out_unc;
  logic [W-1:0] q1, q2, q3, q4;
  logic [2:0] err_pos;
  logic [15:0] cnt_corr, cnt_unc;
  logic in_ready_b, out_valid_b, out_unc_b;
  logic [W-1:0] q1_b, q2_b, q3_b, q4_b;
  logic [2:0] err_pos_b;
  logic [1:0] cnt_corr_b, cnt_unc_b;

  always #5 clk = ~clk;

  matrix_code_row_pipe #(.W(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .p1(p1), .p2(p2), .p3(p3), .p4(p4), .z1(z1), .z2(z2), .z3(z3),
    .correct_en(correct_en), .out_valid(out_valid), .out_ready(out_ready),
    .q1(q1), .q2(q2), .q3(q3), .q4(q4), .err_pos(err_pos), .out_unc(out_unc),
    .cnt_clr(cnt_clr), .cnt_corr(cnt_corr), .cnt_unc(cnt_unc));

  matrix_code_row_pipe #(.W(W), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .p1(p1), .p2(p2), .p3(p3), .p4(p4), .z1(z1), .z2(z2), .z3(z3),
    .correct_en(correct_en), .out_valid(out_valid_b), .out_ready(out_ready),
    .q1(q1_b), .q2(q2_b), .q3(q3_b), .q4(q4_b), .err_pos(err_pos_b), .out_unc(out_unc_b),
    .cnt_clr(cnt_clr), .cnt_corr(cnt_corr_b), .cnt_unc(cnt_unc_b));

  row_t txq[$];
  exp_t expq[$];
  int nchk = 0, nerr = 0, cyc = 0, nacc = 0, nout = 0;
  int mcorr = 0, munc = 0, mcorr_b = 0, munc_b = 0;
  bit lat_chk = 1'b0, stalled = 1'b0;
  logic [3:0][W-1:0] hq;
  logic [2:0] hpos;
  logic hunc;

  // Reference: a single corrupted word k leaves the same nonzero value in
  // exactly the check equations that contain word k (its column mask).
  function automatic exp_t model(row_t r);
    exp_t e;
    logic [2:0][W-1:0] s;
    logic [2:0] nz;
    logic [2:0] col [1:7];
    logic [W-1:0] v;
    bit ok;
    col[1] = 3'b111; col[2] = 3'b011; col[3] = 3'b101; col[4] = 3'b110;
    col[5] = 3'b001; col[6] = 3'b010; col[7] = 3'b100;
    s[0] = r.p[0] ^ r.p[1] ^ r.p[2] ^ r.z[0];
    s[1] = r.p[0] ^ r.p[1] ^ r.p[3] ^ r.z[1];
    s[2] = r.p[0] ^ r.p[2] ^ r.p[3] ^ r.z[2];
    e.q = r.p; e.pos = 3'd0; e.unc = 1'b0; e.cyc = 0;
    for (int i = 0; i < 3; i++) nz[i] = (s[i] != 0);
    if (nz == 3'b000) return e;
    for (int k = 1; k <= 7; k++) begin
      if (nz == col[k]) begin
        v = '0; ok = 1'b1;
        for (int i = 0; i < 3; i++)
          if (nz[i]) begin
            if (v == 0) v = s[i];
            else if (s[i] != v) ok = 1'b0;
          end
        if (ok) begin
          e.pos = k[2:0];
          if (k <= 4 && r.ce) e.q[k-1] = e.q[k-1] ^ v;
          return e;
        end
      end
    end
    e.unc = 1'b1;
    return e;
  endfunction

  function automatic row_t mkrow(logic [W-1:0] a, b, c, d, x, y, w, logic ce);
    row_t r;
    r.p = {d, c, b, a}; r.z = {w, y, x}; r.ce = ce;
    return r;
  endfunction

  function automatic row_t rand_row();
    row_t r;
    int nf, pos;
    logic [W-1:0] f;
    for (int i = 0; i < 4; i++) r.p[i] = W'($urandom);
    r.z[0] = r.p[0] ^ r.p[1] ^ r.p[2];
    r.z[1] = r.p[0] ^ r.p[1] ^ r.p[3];
    r.z[2] = r.p[0] ^ r.p[2] ^ r.p[3];
    r.ce = ($urandom_range(0, 3) != 0);
    nf = $urandom_range(0, 2);
    for (int j = 0; j < nf; j++) begin
      pos = $urandom_range(0, 6);
      f = W'($urandom_range(1, (1 << W) - 1));
      if (pos < 4) r.p[pos] = r.p[pos] ^ f;
      else r.z[pos-4] = r.z[pos-4] ^ f;
    end
    return r;
  endfunction

  task automatic step(input bit ordy, input bit clr);
    exp_t x;
    if (txq.size() > 0) begin
      in_valid = 1'b1;
      {p4, p3, p2, p1} = txq[0].p;
      {z3, z2, z1} = txq[0].z;
      correct_en = txq[0].ce;
    end else in_valid = 1'b0;
    out_ready = ordy;
    cnt_clr = clr;
    @(negedge clk);
    nchk++;
    if (cnt_corr !== mcorr[15:0] || cnt_unc !== munc[15:0]) begin
      nerr++;
      $display("FAIL counters cyc=%0d: got corr=%0d unc=%0d, want corr=%0d unc=%0d",
               cyc, cnt_corr, cnt_unc, mcorr, munc);
    end
    nchk++;
    if (cnt_corr_b !== mcorr_b[1:0] || cnt_unc_b !== munc_b[1:0]) begin
      nerr++;
      $display("FAIL counters_w2 cyc=%0d: got corr=%0d unc=%0d, want corr=%0d unc=%0d",
               cyc, cnt_corr_b, cnt_unc_b, mcorr_b, munc_b);
    end
    nchk++;
    if ({in_ready_b, out_valid_b, q4_b, q3_b, q2_b, q1_b, err_pos_b, out_unc_b} !==
        {in_ready, out_valid, q4, q3, q2, q1, err_pos, out_unc}) begin
      nerr++;
      $display("FAIL twin_sync cyc=%0d: got vld=%b q=%h, want vld=%b q=%h", cyc,
               out_valid_b, {q4_b, q3_b, q2_b, q1_b}, out_valid, {q4, q3, q2, q1});
    end
    if (ordy) begin
      nchk++;
      if (in_ready !== 1'b1) begin
        nerr++;
        $display("FAIL in_ready_open cyc=%0d: got %b, want 1", cyc, in_ready);
      end
    end
    if (stalled) begin
      nchk++;
      if (out_valid !== 1'b1 || {q4, q3, q2, q1} !== hq || err_pos !== hpos || out_unc !== hunc) begin
        nerr++;
        $display("FAIL hold cyc=%0d: got vld=%b q=%h pos=%0d unc=%b, want vld=1 q=%h pos=%0d unc=%b",
                 cyc, out_valid, {q4, q3, q2, q1}, err_pos, out_unc, hq, hpos, hunc);
      end
    end
    if (in_valid && in_ready) begin
      x = model(txq.pop_front());
      x.cyc = cyc;
      expq.push_back(x);
      nacc++;
    end
    if (out_valid && out_ready) begin
      nout++;
      nchk++;
      if (expq.size() == 0) begin
        nerr++;
        $display("FAIL spurious_row cyc=%0d: got q=%h, want no row", cyc, {q4, q3, q2, q1});
      end else begin
        x = expq.pop_front();
        if ({q4, q3, q2, q1} !== x.q || err_pos !== x.pos || out_unc !== x.unc) begin
          nerr++;
          $display("FAIL row cyc=%0d: got q=%h pos=%0d unc=%b, want q=%h pos=%0d unc=%b",
                   cyc, {q4, q3, q2, q1}, err_pos, out_unc, x.q, x.pos, x.unc);
        end
        if (lat_chk) begin
          nchk++;
          if (cyc - x.cyc != 2) begin
            nerr++;
            $display("FAIL latency cyc=%0d: got %0d, want 2", cyc, cyc - x.cyc);
          end
        end
        if (x.unc) begin
          if (munc < 65535) munc++;
          if (munc_b < 3) munc_b++;
        end else if (x.pos != 0) begin
          if (mcorr < 65535) mcorr++;
          if (mcorr_b < 3) mcorr_b++;
        end
      end
    end
    if (clr) begin
      mcorr = 0; munc = 0; mcorr_b = 0; munc_b = 0;
    end
    stalled = out_valid && !out_ready;
    hq = {q4, q3, q2, q1}; hpos = err_pos; hunc = out_unc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while ((txq.size() > 0 || expq.size() > 0) && n < 60) begin
      step(1'b1, 1'b0);
      n++;
    end
    nchk++;
    if (txq.size() > 0 || expq.size() > 0) begin
      nerr++;
      $display("FAIL drain_timeout: got %0d rows pending, want 0", txq.size() + expq.size());
    end
    step(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0; correct_en = 1'b0;
    {p1, p2, p3, p4, z1, z2, z3} = '0;
    @(posedge clk);
    #1;
    nchk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || {q4, q3, q2, q1} !== '0 || err_pos !== 3'd0 ||
        out_unc !== 1'b0 || cnt_corr !== 16'd0 || cnt_unc !== 16'd0 || cnt_corr_b !== 2'd0) begin
      nerr++;
      $display("FAIL reset_state: got vld=%b rdy=%b q=%h pos=%0d unc=%b cc=%0d cu=%0d, want 0 1 0 0 0 0 0",
               out_valid, in_ready, {q4, q3, q2, q1}, err_pos, out_unc, cnt_corr, cnt_unc);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    lat_chk = 1'b1;
    txq.push_back(mkrow(8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h77, 8'h66, 1'b1));
    txq.push_back(mkrow(8'h11, 8'h2A, 8'h33, 8'h44, 8'h00, 8'h77, 8'h66, 1'b1));
    txq.push_back(mkrow(8'h11, 8'h2A, 8'h33, 8'h44, 8'h00, 8'h77, 8'h66, 1'b0));
    txq.push_back(mkrow(8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h77, 8'h67, 1'b1));
    txq.push_back(mkrow(8'h10, 8'h22, 8'h33, 8'h44, 8'h00, 8'h77, 8'h66, 1'b1));
    txq.push_back(mkrow(8'h10, 8'h22, 8'h33, 8'h54, 8'h00, 8'h77, 8'h66, 1'b1));
    drain();
    lat_chk = 1'b0;
    nchk++;
    if (cnt_corr !== 16'd4 || cnt_unc !== 16'd1 || cnt_corr_b !== 2'd3) begin
      nerr++;
      $display("FAIL directed_counts: got corr=%0d unc=%0d corr_w2=%0d, want 4 1 3",
               cnt_corr, cnt_unc, cnt_corr_b);
    end
  endtask

  task automatic test_backpressure();
    int a0, o0;
    for (int i = 0; i < 4; i++) txq.push_back(rand_row());
    a0 = nacc;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    nchk++;
    if (nacc - a0 != 2 || in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL stall_accept: got accepted=%0d in_ready=%b, want 2 0", nacc - a0, in_ready);
    end
    o0 = nout;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    nchk++;
    if (nout - o0 != 4) begin
      nerr++;
      $display("FAIL release_rate: got %0d rows in 4 cycles, want 4", nout - o0);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) != 0) txq.push_back(rand_row());
      step($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
    end
    drain();
  endtask

  task automatic test_saturation();
    step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++)
      txq.push_back(mkrow(8'h11, 8'h2A, 8'h33, 8'h44, 8'h00, 8'h77, 8'h66, 1'b1));
    drain();
    nchk++;
    if (cnt_corr_b !== 2'd3 || cnt_corr !== 16'd5) begin
      nerr++;
      $display("FAIL saturate: got corr_w2=%0d corr=%0d, want 3 5", cnt_corr_b, cnt_corr);
    end
  endtask

  task automatic test_cnt_clr();
    int o0;
    txq.push_back(mkrow(8'h10, 8'h22, 8'h33, 8'h44, 8'h00, 8'h77, 8'h66, 1'b1));
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    o0 = nout;
    step(1'b1, 1'b1);
    nchk++;
    if (nout - o0 != 1 || cnt_corr !== 16'd0 || cnt_corr_b !== 2'd0) begin
      nerr++;
      $display("FAIL clr_priority: got handshakes=%0d corr=%0d corr_w2=%0d, want 1 0 0",
               nout - o0, cnt_corr, cnt_corr_b);
    end
  endtask

  task automatic test_reset_midstream();
    txq.push_back(mkrow(8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h77, 8'h67, 1'b1));
    drain();
    for (int i = 0; i < 3; i++) txq.push_back(rand_row());
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    nchk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || cnt_corr !== 16'd0 || cnt_unc !== 16'd0 ||
        cnt_corr_b !== 2'd0 || err_pos !== 3'd0) begin
      nerr++;
      $display("FAIL reset_midstream: got vld=%b rdy=%b corr=%0d unc=%0d pos=%0d, want 0 1 0 0 0",
               out_valid, in_ready, cnt_corr, cnt_unc, err_pos);
    end
    txq.delete(); expq.delete();
    mcorr = 0; munc = 0; mcorr_b = 0; munc_b = 0; stalled = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    txq.push_back(mkrow(8'h11, 8'h22, 8'h3B, 8'h44, 8'h00, 8'h77, 8'h66, 1'b1));
    drain();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_saturation();
    test_cnt_clr();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/matrix_code_row_pipe.md
Name: matrix_code_row_pipe

Overview:
- Pipelined, parametrised matrix-code row checker/corrector.
- One row per transfer: four W-bit data words p1..p4 and three stored check words z1..z3, with check equations c1=p1^p2^p3, c2=p1^p2^p4, c3=p1^p3^p4.
- Locates and repairs a single corrupted data word, flags check-word-only errors, and detects inconsistent (uncorrectable) syndromes.
- Sits between the protected row store and downstream compute; valid/ready on both sides, with saturating error-event counters for the fault monitor.

Parameters:
- W, 8, width of each data and check word.
- CNT_W, 16, width of each event counter.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  row presented on p1..p4, z1..z3.
- in_ready  output  1  block can accept a row this cycle.
- p1, p2, p3, p4  input  W each  received data words.
- z1, z2, z3  input  W each  received check words.
- correct_en  input  1  1 = repair data; 0 = detect only, pass data raw. Sampled with the row.
- out_valid  output  1  result row valid.
- out_ready  input  1  downstream accepts the result.
- q1, q2, q3, q4  output  W each  corrected (or raw) data words.
- err_pos  output  3  0 = clean; 1..4 = data word pk in error; 5..7 = check word z1..z3 in error.
- out_unc  output  1  uncorrectable syndrome.
- cnt_clr  input  1  synchronous clear of both counters.
- cnt_corr  output  CNT_W  count of delivered rows with err_pos != 0 and out_unc = 0.
- cnt_unc  output  CNT_W  count of delivered rows with out_unc = 1.

Behaviour:
- Reset (asynchronous, active-high): v1, v2, q*, err_pos, out_unc, cnt_corr and cnt_unc all go to 0. in_ready is 1 after reset. Rows in flight are discarded with no partial output.
- Stage 1 registers p*, z* and correct_en, and computes syndromes s_i = c_i ^ z_i.
- Stage 2 classifies, corrects, and registers q*, err_pos and out_unc.
- Handshake:
  - adv2 = !v2 | out_ready.
  - adv1 = !v1 | adv2.
  - in_ready = adv1 (combinational).
  - A row is accepted when in_valid & in_ready.
  - Throughput is one row per cycle.
  - Latency: a row accepted at edge k appears with out_valid = 1 after edge k+2 when there is no backpressure.
- While out_valid & !out_ready, all outputs are held stable. Row order is always preserved; no row is dropped or duplicated.
- Classification, where n = number of nonzero s_i:
  - n = 0: clean. err_pos = 0.
  - n = 1: check-word error. err_pos = 4 + i. Data is passed through unchanged.
  - s1, s2, s3 all nonzero and all equal: data word p1 in error. err_pos = 1. q1 = p1 ^ s1.
  - s1 = s2 != 0 and s3 = 0: p2 in error. err_pos = 2. q2 = p2 ^ s1.
  - s1 = s3 != 0 and s2 = 0: p3 in error. err_pos = 3. q3 = p3 ^ s1.
  - s2 = s3 != 0 and s1 = 0: p4 in error. err_pos = 4. q4 = p4 ^ s2.
  - Any other pattern (n >= 2 with unequal nonzero syndromes): out_unc = 1, err_pos = 0, data passed raw.
- With correct_en = 0: classification, err_pos, out_unc and counters behave identically, but q* = p* raw.
- Counters:
  - Update only on an output handshake (out_valid & out_ready).
  - Saturate at all-ones; no wrap.
  - cnt_clr forces both to 0 and takes priority over a simultaneous increment.
- All arithmetic is bitwise XOR on W-bit words; there is no carry.

Test Plan:
- W=8, clean row p=11,22,33,44, z=00,77,66 (hex) -> two cycles later q=11,22,33,44, err_pos=0, out_unc=0, counters unchanged.
- Same row with p2=2A -> s1=s2=08, s3=0 -> q2=22, err_pos=2, cnt_corr=1. Repeat with correct_en=0 -> q2=2A, err_pos=2, cnt_corr=2.
- Clean data with z3=67 -> q unchanged, err_pos=7, cnt_corr increments. p1=10 (all s=01) -> q1=11, err_pos=1.
- p1=10 and p4=54 -> s1=01, s2=11, s3=11 (unequal) -> out_unc=1, q raw, cnt_unc=1, cnt_corr unchanged.
- Stream 4 rows with out_ready=0 for 5 cycles:
  - in_ready drops after 2 rows are accepted.
  - outputs stay stable while stalled.
  - on release, all 4 rows emerge in order, one per cycle.
- CNT_W=2: 5 corrected rows -> cnt_corr saturates at 3. cnt_clr asserted in the same cycle as a handshake -> 0. rst asserted mid-stream -> out_valid=0 immediately, counters 0, in_ready=1.
